// File: rtl/delta_out_if.sv
// Handshake and data bus between the backprop controller and the
// output-layer delta stage. Activations, targets and derivatives are packed
// Q6.10 words, element k at bits [16k+15:16k].
interface delta_out_if #(
  parameter int N_OUT = 2
);

  logic                  start;
  logic [16*N_OUT-1:0]   a_bus;
  logic [16*N_OUT-1:0]   t_bus;
  logic [16*N_OUT-1:0]   dadz_bus;
  logic [16*N_OUT-1:0]   delta_bus;
  logic                  busy;
  logic                  done;

  modport master (
    output start,
    output a_bus,
    output t_bus,
    output dadz_bus,
    input  delta_bus,
    input  busy,
    input  done
  );

  modport slave (
    input  start,
    input  a_bus,
    input  t_bus,
    input  dadz_bus,
    output delta_bus,
    output busy,
    output done
  );

endinterface

// File: rtl/delta_out.sv
// Output-layer error stage: delta_j = (a_j - t_j) * dadz_j in Q6.10, one
// shared multiplier walked across the N_OUT neurons after each start.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; operands latched on the accepting edge
// SUB   | err = a[k] - t[k] (17-bit, exact), dz = dadz[k]
// MUL   | delta[k] = sat(err * dz); advance k or finish
// DONE  | one-cycle completion pulse, start ignored here
module delta_out #(
  parameter int N_OUT = 2
) (
  input  logic        clk,
  input  logic        res,
  delta_out_if.slave  bus
);

  localparam int KW = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N_OUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    MUL  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                    state_q, state_d;
  logic [KW-1:0]             k_q, k_d;
  logic [N_OUT-1:0][15:0]    a_q, a_d;
  logic [N_OUT-1:0][15:0]    t_q, t_d;
  logic [N_OUT-1:0][15:0]    dadz_q, dadz_d;
  logic signed [16:0]        err_q, err_d;
  logic signed [15:0]        dz_q, dz_d;
  logic [N_OUT-1:0][15:0]    delta_q, delta_d;

  logic signed [32:0]        prod;
  logic signed [32:0]        prod_sh;
  logic [15:0]               prod_sat;

  // Saturating Q12.20 -> Q6.10 conversion of the shared multiplier output.
  // After the arithmetic shift, the value fits in 16 bits exactly when the
  // upper 18 bits are pure sign extension (equivalent to prod[32:25] equal).
  always_comb begin
    prod     = err_q * dz_q;
    prod_sh  = prod >>> 10;
    prod_sat = prod_sh[15:0];
    if (!((&prod_sh[32:15]) || (~|prod_sh[32:15]))) begin
      prod_sat = prod[32] ? 16'h8000 : 16'h7FFF;
    end
  end

  // Next-state and datapath updates; outputs are decoded from state_q.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    a_d     = a_q;
    t_d     = t_q;
    dadz_d  = dadz_q;
    err_d   = err_q;
    dz_d    = dz_q;
    delta_d = delta_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = bus.a_bus;
          t_d     = bus.t_bus;
          dadz_d  = bus.dadz_bus;
          k_d     = '0;
          state_d = SUB;
        end
      end
      SUB: begin
        // Sign-extend to 17 bits so the difference can never overflow.
        err_d   = {a_q[k_q][15], a_q[k_q]} - {t_q[k_q][15], t_q[k_q]};
        dz_d    = dadz_q[k_q];
        state_d = MUL;
      end
      MUL: begin
        delta_d[k_q] = prod_sat;
        if (k_q == K_LAST) begin
          state_d = DONE;
        end else begin
          k_d     = k_q + KW'(1);
          state_d = SUB;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (res) begin
      state_q <= IDLE;
      k_q     <= '0;
      a_q     <= '0;
      t_q     <= '0;
      dadz_q  <= '0;
      err_q   <= '0;
      dz_q    <= '0;
      delta_q <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      a_q     <= a_d;
      t_q     <= t_d;
      dadz_q  <= dadz_d;
      err_q   <= err_d;
      dz_q    <= dz_d;
      delta_q <= delta_d;
    end
  end

  assign bus.delta_bus = delta_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == DONE);

endmodule

// File: tb/tb_delta_out.sv
// Directed bench for delta_out with N_OUT=2: a table of operand sets with
// hand-computed deltas run back-to-back, then handshake-abuse and
// mid-operation reset sequences.
module tb_delta_out;

  logic clk;
  logic res;

  delta_out_if #(.N_OUT(2)) dif ();

  delta_out #(.N_OUT(2)) dut (
    .clk (clk),
    .res (res),
    .bus (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a0, t0, d0;
    logic [15:0] a1, t1, d1;
    logic [15:0] e0, e1;
  } vec_t;

  vec_t vecs[6];

  int n_chk  = 0;
  int n_pass = 0;

  logic [15:0] prev0;
  logic [15:0] prev1;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, required %h", name, act, req);
  endtask

  // Starts one operation in the current (IDLE) cycle and follows it through
  // to the first IDLE cycle after done, checking every cycle.
  task automatic run_op(input vec_t v, input string tag, input bit disturb);
    dif.a_bus    = {v.a1, v.a0};
    dif.t_bus    = {v.t1, v.t0};
    dif.dadz_bus = {v.d1, v.d0};
    dif.start    = 1'b1;
    tick();
    dif.start    = 1'b0;
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("%s c%0d busy", tag, c), 16'(dif.busy), 16'd1);
      chk($sformatf("%s c%0d done", tag, c), 16'(dif.done), (c == 4) ? 16'd1 : 16'd0);
      chk($sformatf("%s c%0d delta0", tag, c), dif.delta_bus[15:0],  (c >= 2) ? v.e0 : prev0);
      chk($sformatf("%s c%0d delta1", tag, c), dif.delta_bus[31:16], (c >= 4) ? v.e1 : prev1);
      if (disturb) begin
        if (c == 0) begin
          dif.a_bus    = ~dif.a_bus;
          dif.t_bus    = 32'h1234_5678;
          dif.dadz_bus = 32'h7FFF_7FFF;
        end
        if (c == 1) dif.start = 1'b1;
        if (c == 2) dif.start = 1'b0;
        if (c == 4) dif.start = 1'b1;
      end
      tick();
    end
    dif.start = 1'b0;
    chk({tag, " idle busy"}, 16'(dif.busy), 16'd0);
    chk({tag, " idle done"}, 16'(dif.done), 16'd0);
    chk({tag, " held delta0"}, dif.delta_bus[15:0],  v.e0);
    chk({tag, " held delta1"}, dif.delta_bus[31:16], v.e1);
    if (disturb) begin
      tick();
      chk({tag, " no queued op busy"}, 16'(dif.busy), 16'd0);
      chk({tag, " no queued op done"}, 16'(dif.done), 16'd0);
    end
    prev0 = v.e0;
    prev1 = v.e1;
  endtask

  initial begin
    // nominal
    vecs[0] = '{a0:16'h0300, t0:16'h0400, d0:16'h00C0, a1:16'h0100, t1:16'h0000, d1:16'h00C0,
                e0:16'hFFD0, e1:16'h0030};
    // saturation both directions
    vecs[1] = '{a0:16'h7FFF, t0:16'h8000, d0:16'h7FFF, a1:16'h8000, t1:16'h7FFF, d1:16'h7FFF,
                e0:16'h7FFF, e1:16'h8000};
    // truncation toward minus infinity, zero error
    vecs[2] = '{a0:16'h0000, t0:16'h0001, d0:16'h0001, a1:16'h0155, t1:16'h0155, d1:16'h0400,
                e0:16'hFFFF, e1:16'h0000};
    // 1.0*0.5 and -2.0*1.0
    vecs[3] = '{a0:16'h0800, t0:16'h0400, d0:16'h0200, a1:16'hFC00, t1:16'h0400, d1:16'h0400,
                e0:16'h0200, e1:16'hF800};
    // -768/1024 floors to -1 LSB; +768/1024 floors to 0
    vecs[4] = '{a0:16'h0000, t0:16'h0003, d0:16'h0100, a1:16'h0003, t1:16'h0000, d1:16'h0100,
                e0:16'hFFFF, e1:16'h0000};
    // positive saturation from a large product of in-range operands
    vecs[5] = '{a0:16'h7FFF, t0:16'h0000, d0:16'h7FFF, a1:16'h0000, t1:16'h7FFF, d1:16'h7FFF,
                e0:16'h7FFF, e1:16'h8000};

    res          = 1'b1;
    dif.start    = 1'b0;
    dif.a_bus    = '0;
    dif.t_bus    = '0;
    dif.dadz_bus = '0;
    prev0        = '0;
    prev1        = '0;
    tick();
    tick();
    chk("reset busy",  16'(dif.busy), 16'd0);
    chk("reset done",  16'(dif.done), 16'd0);
    chk("reset delta", dif.delta_bus[15:0] | dif.delta_bus[31:16], 16'h0000);
    res = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("idle no start busy %0d", i), 16'(dif.busy), 16'd0);
    end

    // table vectors, each start issued on the first IDLE cycle after done
    for (int i = 0; i < 6; i++) run_op(vecs[i], $sformatf("vec%0d", i), 1'b0);

    // restart at E2 and in DONE, buses changed right after acceptance
    run_op(vecs[0], "handshake", 1'b1);

    // reset at E3 aborts with no done pulse
    dif.a_bus    = {vecs[3].a1, vecs[3].a0};
    dif.t_bus    = {vecs[3].t1, vecs[3].t0};
    dif.dadz_bus = {vecs[3].d1, vecs[3].d0};
    dif.start    = 1'b1;
    tick();
    dif.start    = 1'b0;
    tick();
    tick();
    chk("pre-reset delta0", dif.delta_bus[15:0], vecs[3].e0);
    res = 1'b1;
    tick();
    res = 1'b0;
    chk("abort busy",   16'(dif.busy), 16'd0);
    chk("abort done",   16'(dif.done), 16'd0);
    chk("abort delta0", dif.delta_bus[15:0],  16'h0000);
    chk("abort delta1", dif.delta_bus[31:16], 16'h0000);
    prev0 = '0;
    prev1 = '0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("post-abort done %0d", i), 16'(dif.done), 16'd0);
    end
    run_op(vecs[1], "after reset", 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required finish before 200000");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/delta_out.md
Name: delta_out

Overview:
- Output-layer error stage of the backprop datapath. It sits directly downstream of the sigmoid-derivative stage and consumes its dadz values.
- For each of N_OUT output neurons it computes delta_j = (a_j - t_j) * dadz_j in Q6.10.
- It time-shares one multiplier under a start/done handshake.
- The delta vector feeds the hidden-layer error and weight-update stages.

Parameters:
- N_OUT, 2, number of output neurons processed per start (j = 0..N_OUT-1, minimum 1).

Ports:
- clk  input  1  system clock, rising edge.
- res  input  1  reset, synchronous, active-high.
- start  input  1  single-cycle request; sampled only in IDLE.
- a_bus  input  16*N_OUT  output activations, signed Q6.10; element k at bits [16k+15:16k].
- t_bus  input  16*N_OUT  targets, signed Q6.10, same packing.
- dadz_bus  input  16*N_OUT  sigmoid derivatives from the dadz stage, signed Q6.10, same packing.
- delta_bus  output  16*N_OUT  deltas, signed Q6.10, same packing; registered.
- busy  output  1  high while state is not IDLE.
- done  output  1  high for exactly one cycle when delta_bus is complete.

Behaviour:
- Format: 16-bit signed, 10 fractional bits. 1.0 = 0x0400.
- Reset (res=1 at a clk edge), regardless of state: state=IDLE, k=0, delta_bus=0, busy=0, done=0, internal err/dz regs=0.
  - Reset mid-operation aborts the operation with no done pulse.
- State machine (Moore): IDLE, SUB, MUL, DONE.
  - IDLE:
    - If start=1: latch a_bus, t_bus and dadz_bus into internal copies, set k=0, go to SUB.
    - If start=0: stay in IDLE.
    - delta_bus holds its previous value.
  - SUB: err = a[k] - t[k] as 17-bit signed, with no overflow. dz = dadz[k]. Go to MUL.
  - MUL:
    - prod = err * dz as 33-bit signed.
    - delta[k] = sat(prod), written at this edge.
    - If k == N_OUT-1, go to DONE; else k = k+1 and go to SUB.
  - DONE: go to IDLE.
- Outputs:
  - busy = (state != IDLE).
  - done = (state == DONE).
- Latency:
  - With start sampled at edge E0, done is high in the cycle after edge E(2N_OUT).
  - For N_OUT=2: start at E0, done during the cycle between E4 and E5.
  - All deltas are valid by done and held stable until the MUL of the next operation.
- Input capture: inputs are captured only at the accepting edge. Bus changes after acceptance do not affect the result.
- start while busy, including in the DONE cycle: ignored; no queuing.
- Saturation, sat(prod):
  - If prod[32:25] are all equal: result = prod[25:10], i.e. arithmetic shift right by 10 with truncation toward minus infinity.
  - Else if prod < 0: result = 0x8000.
  - Else: result = 0x7FFF.
- delta_bus slots not yet written in the current operation keep their old values until their own MUL cycle.

Test Plan:
- Nominal: N_OUT=2.
  - Inputs: a0=0x0300, t0=0x0400, dadz0=0x00C0; a1=0x0100, t1=0x0000, dadz1=0x00C0; pulse start.
  - Expect busy=1 for 5 cycles, done=1 for one cycle after E4, delta0=0xFFD0 (-0.046875), delta1=0x0030 (0.046875).
- Saturation:
  - Inputs: a0=0x7FFF, t0=0x8000, dadz0=0x7FFF; a1=0x8000, t1=0x7FFF, dadz1=0x7FFF.
  - Expect delta0=0x7FFF, delta1=0x8000.
- Truncation:
  - Inputs: a0=0x0000, t0=0x0001, dadz0=0x0001 (err=-1, prod=-1); a1=t1.
  - Expect delta0=0xFFFF, delta1=0x0000.
- Handshake:
  - Re-pulse start at E2 and in the DONE cycle, and change all input buses at E1.
  - Expect exactly one done, results computed from the values captured at E0, and the next operation only on a start issued in IDLE.
- Reset mid-operation:
  - Assert res at E3 of an operation.
  - Expect next cycle: busy=0, done=0, delta_bus=0, no done pulse.
  - A subsequent start must produce correct results.
- Back-to-back: issue a start on the first IDLE cycle after done.
  - Expect the new operation accepted with the same latency.
  - Expect old deltas held until overwritten slot-by-slot.
